// File: rtl/fuzz_pkg.sv
// rtl/fuzz_pkg.sv - shared types and constants for the fuzz campaign collector
package fuzz_pkg;

    localparam int IP_OUT_W  = 33;
    localparam int RUN_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_PASS    = 2'b00,
        ST_CRASH   = 2'b01,
        ST_TIMEOUT = 2'b10
    } fuzz_status_t;

    typedef struct packed {
        logic [RUN_W_DEF-1:0] run_idx;
        fuzz_status_t         status;
        logic [IP_OUT_W-1:0]  ip_output;
    } fuzz_record_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_ACK,
        S_PUSH,
        S_GAP,
        S_FINISH
    } coll_state_t;

endpackage

// File: rtl/fuzz_campaign_collector_if.sv
// rtl/fuzz_campaign_collector_if.sv - fuzzer handshake and result record stream
interface fuzz_campaign_collector_if #(
    parameter int RUN_W = 16
);
    import fuzz_pkg::*;

    localparam int REC_W = RUN_W + 2 + IP_OUT_W;

    logic                fz_enable;
    logic                fz_ack;
    logic                fz_crash;
    logic [IP_OUT_W-1:0] fz_ip_output;
    logic                rec_valid;
    logic                rec_ready;
    logic [REC_W-1:0]    rec_data;

    modport master (
        output fz_enable,
        output rec_valid,
        output rec_data,
        input  fz_ack,
        input  fz_crash,
        input  fz_ip_output,
        input  rec_ready
    );

    modport slave (
        input  fz_enable,
        input  rec_valid,
        input  rec_data,
        output fz_ack,
        output fz_crash,
        output fz_ip_output,
        output rec_ready
    );

endinterface

// File: rtl/fuzz_result_fifo.sv
// rtl/fuzz_result_fifo.sv - synchronous show-ahead result FIFO
module fuzz_result_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 51
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] head_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          pop;

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign head_o  = mem_q[rd_q];
    assign pop     = pop_i && valid_o;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop)    rd_q <= rd_q + 1'b1;
            case ({push_i, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fuzz_campaign_collector.sv
// rtl/fuzz_campaign_collector.sv - drives fuzzer runs, watchdogs acks, queues result records
module fuzz_campaign_collector
    import fuzz_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GAP_CYCLES     = 2,
    parameter int RUN_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [RUN_W-1:0]          num_runs,
    input  logic                      abort,
    fuzz_campaign_collector_if.master bus,
    output logic                      busy,
    output logic                      done,
    output logic [RUN_W-1:0]          pass_cnt,
    output logic [RUN_W-1:0]          crash_cnt,
    output logic [RUN_W-1:0]          timeout_cnt
);
    localparam int REC_W  = RUN_W + 2 + IP_OUT_W;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    coll_state_t         state_q;
    logic                fz_enable_q;
    logic                done_q;
    logic [RUN_W-1:0]    num_runs_q;
    logic [RUN_W-1:0]    run_idx_q;
    logic [RUN_W-1:0]    run_idx_d;
    logic [WAIT_W-1:0]   wait_q;
    logic [GAP_W-1:0]    gap_q;
    logic [RUN_W-1:0]    pass_q;
    logic [RUN_W-1:0]    crash_q;
    logic [RUN_W-1:0]    timeout_q;
    fuzz_status_t        rec_status_q;
    logic [IP_OUT_W-1:0] rec_ip_q;

    logic             abort_hit;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_valid;
    logic [REC_W-1:0] fifo_head;

    function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign run_idx_d = run_idx_q + 1'b1;
    assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_FINISH);
    assign fifo_pop  = fifo_valid && bus.rec_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the record.
    assign fifo_push = (state_q == S_PUSH) && !abort_hit && (!fifo_full || fifo_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fz_enable_q  <= 1'b0;
            done_q       <= 1'b0;
            num_runs_q   <= '0;
            run_idx_q    <= '0;
            wait_q       <= '0;
            gap_q        <= '0;
            pass_q       <= '0;
            crash_q      <= '0;
            timeout_q    <= '0;
            rec_status_q <= ST_PASS;
            rec_ip_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_hit) begin
                fz_enable_q <= 1'b0;
                state_q     <= S_FINISH;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (num_runs != '0) begin
                                num_runs_q  <= num_runs;
                                run_idx_q   <= '0;
                                pass_q      <= '0;
                                crash_q     <= '0;
                                timeout_q   <= '0;
                                fz_enable_q <= 1'b1;
                                state_q     <= S_ARM;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    S_ARM: begin
                        wait_q  <= '0;
                        state_q <= S_WAIT_ACK;
                    end
                    S_WAIT_ACK: begin
                        wait_q <= wait_q + 1'b1;
                        if (bus.fz_ack) begin
                            rec_status_q <= bus.fz_crash ? ST_CRASH : ST_PASS;
                            rec_ip_q     <= bus.fz_ip_output;
                            fz_enable_q  <= 1'b0;
                            state_q      <= S_PUSH;
                        end else if (wait_q == WAIT_LAST) begin
                            rec_status_q <= ST_TIMEOUT;
                            rec_ip_q     <= '0;
                            fz_enable_q  <= 1'b0;
                            state_q      <= S_PUSH;
                        end
                    end
                    S_PUSH: begin
                        if (fifo_push) begin
                            case (rec_status_q)
                                ST_PASS:    pass_q    <= sat_inc(pass_q);
                                ST_CRASH:   crash_q   <= sat_inc(crash_q);
                                ST_TIMEOUT: timeout_q <= sat_inc(timeout_q);
                                default:    pass_q    <= pass_q;
                            endcase
                            gap_q   <= '0;
                            state_q <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (gap_q == GAP_LAST) begin
                            run_idx_q <= run_idx_d;
                            if (run_idx_d == num_runs_q) begin
                                state_q <= S_FINISH;
                            end else begin
                                fz_enable_q <= 1'b1;
                                state_q     <= S_ARM;
                            end
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                    S_FINISH: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    fuzz_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i ({run_idx_q, rec_status_q, rec_ip_q}),
        .pop_i       (fifo_pop),
        .valid_o     (fifo_valid),
        .head_o      (fifo_head),
        .full_o      (fifo_full)
    );

    assign bus.fz_enable = fz_enable_q;
    assign bus.rec_valid = fifo_valid;
    assign bus.rec_data  = fifo_head;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign pass_cnt      = pass_q;
    assign crash_cnt     = crash_q;
    assign timeout_cnt   = timeout_q;

endmodule
